// File: rtl/dual_input_debounce_pkg.sv
// -----------------------------------------------------------------------------
// dual_input_debounce_pkg
// Shared constants and helpers for the dual-input debounce block.
//   DEFAULT_DEBOUNCE_CYCLES : default persistence requirement, in clk cycles
//   SYNC_STAGES             : depth of the per-channel input synchronizer
//   cnt_width(n)            : counter width able to hold 0..n, never below 1
// -----------------------------------------------------------------------------
package dual_input_debounce_pkg;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 4;
    localparam int unsigned SYNC_STAGES             = 2;

    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/dual_input_debounce_if.sv
// -----------------------------------------------------------------------------
// dual_input_debounce_if
// Signal bundle between the raw switch inputs, the debouncer and the gate.
//   raw_a, raw_b     : unsynchronized bouncy inputs
//   a, b             : debounced levels feeding the AND gate
//   rise_a, rise_b   : one-cycle pulses on 0->1 of a / b
//   settled          : both channels idle (no pending transition)
// Modports:
//   master : environment side, drives raw inputs, observes conditioned outputs
//   slave  : debouncer side
// -----------------------------------------------------------------------------
interface dual_input_debounce_if;

    logic raw_a;
    logic raw_b;
    logic a;
    logic b;
    logic rise_a;
    logic rise_b;
    logic settled;

    modport master (
        output raw_a, raw_b,
        input  a, b, rise_a, rise_b, settled
    );

    modport slave (
        input  raw_a, raw_b,
        output a, b, rise_a, rise_b, settled
    );

endinterface

// File: rtl/dual_input_debounce_chan.sv
// -----------------------------------------------------------------------------
// debounce_chan
// One debounce channel: SYNC_STAGES-flop synchronizer, persistence counter and
// registered output level with a registered rising-edge pulse.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   raw   : unsynchronized input
//   q     : debounced level
//   rise  : one-cycle pulse in the first cycle q reads 1
//   idle  : counter is zero and synchronized input agrees with q
// -----------------------------------------------------------------------------
module debounce_chan
    import dual_input_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic q,
    output logic rise,
    output logic idle
);

    localparam int unsigned      CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Pure shift chain: nothing may sit between synchronizer stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    // A differing level must be seen DEBOUNCE_CYCLES consecutive cycles; any
    // return to the current level clears the count, so bounces never accumulate.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        if (sync_out == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync_out;
            cnt_d   = '0;
            rise_d  = sync_out;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
        end
    end

    assign q    = level_q;
    assign rise = rise_q;
    assign idle = (cnt_q == '0) && (sync_out == level_q);

    a_cnt_bounded: assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= CNT_LAST)
        else $error("debounce counter exceeded its last value");

endmodule

// File: rtl/dual_input_debounce.sv
// -----------------------------------------------------------------------------
// dual_input_debounce
// Conditions two raw bouncy inputs into clean levels for the downstream
// two-input AND gate, with rising-edge pulses and a combined settled flag.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   io    : dual_input_debounce_if.slave
//           raw_a/raw_b in; a/b, rise_a/rise_b, settled out
// -----------------------------------------------------------------------------
module dual_input_debounce
    import dual_input_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dual_input_debounce_if.slave  io
);

    logic idle_a;
    logic idle_b;

    debounce_chan #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan_a (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (io.raw_a),
        .q     (io.a),
        .rise  (io.rise_a),
        .idle  (idle_a)
    );

    debounce_chan #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan_b (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (io.raw_b),
        .q     (io.b),
        .rise  (io.rise_b),
        .idle  (idle_b)
    );

    assign io.settled = idle_a & idle_b;

endmodule
